// File: rtl/tt_pad_cfg_ctrl.sv
// Run-time pad configuration controller: shadow/active mode word per pad, atomic break-before-make commit.
// Latency: writes land in shadow next edge; commit takes GUARD_CYC+2 edges (2 edges if nothing changed).
// Backpressure: cfg_ready drops for the whole commit; commits requested while busy are dropped and flagged.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   cfg_valid/cfg_ready      word-write handshake, cfg_addr = pad index, cfg_data = new mode word
//   cfg_commit               single-cycle request to move shadow into active
//   rd_addr/rd_data          registered readback of the active word
//   pad_cfg                  per-pad mode words to the GPIO cells (pad i at [CFG_W*i +: CFG_W])
//   busy, done               commit in progress / one-cycle completion pulse
//   addr_err, commit_err     sticky error flags, cleared by err_clr
module tt_pad_cfg_ctrl #(
   parameter int                      N_PADS      = 64,
   parameter int                      CFG_W       = 16,
   parameter logic [N_PADS*CFG_W-1:0] DEFAULT_CFG = '0,
   parameter logic [N_PADS-1:0]       LOCK_MASK   = '0,
   parameter logic [CFG_W-1:0]        SAFE_CFG    = '0,
   parameter int                      GUARD_CYC   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [7:0]                cfg_addr,
   input  logic [CFG_W-1:0]          cfg_data,
   input  logic                      cfg_commit,
   input  logic [7:0]                rd_addr,
   output logic [CFG_W-1:0]          rd_data,
   output logic [N_PADS*CFG_W-1:0]   pad_cfg,
   output logic                      busy,
   output logic                      done,
   output logic                      addr_err,
   output logic                      commit_err,
   input  logic                      err_clr
);

   // Pad index width; the 8-bit address bus limits N_PADS to 256.
   localparam int AW = (N_PADS > 1) ? $clog2(N_PADS) : 1;
   // Guard counter holds GUARD_CYC-1 at most.
   localparam int CW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISOLATE = 2'd1,
      APPLY   = 2'd2
   } state_t;

   state_t              state;
   logic [CW-1:0]       guard_cnt;
   logic [N_PADS-1:0]   chg;
   logic [CFG_W-1:0]    shadow     [N_PADS];
   logic [CFG_W-1:0]    active     [N_PADS];
   logic [CFG_W-1:0]    shadow_nxt [N_PADS];
   logic [N_PADS-1:0]   chg_nxt;

   logic                wr_in_range;
   logic                wr_locked;
   logic                wr_fire;
   logic                wr_ok;
   logic                wr_bad;
   logic [AW-1:0]       wr_idx;
   logic                rd_in_range;
   logic [AW-1:0]       rd_idx;

   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == APPLY);

   assign wr_idx      = AW'(cfg_addr);
   assign rd_idx      = AW'(rd_addr);
   assign wr_in_range = (32'(cfg_addr) < N_PADS);
   assign rd_in_range = (32'(rd_addr) < N_PADS);
   // Out-of-range addresses short-circuit before the lock lookup is used.
   assign wr_locked   = wr_in_range && LOCK_MASK[wr_idx];
   assign wr_fire     = cfg_valid && cfg_ready;
   assign wr_ok       = wr_fire && wr_in_range && !wr_locked;
   assign wr_bad      = wr_fire && !(wr_in_range && !wr_locked);

   // Shadow as it will be after this edge, so a write landing together with
   // cfg_commit is part of the change mask and of the applied words.
   always_comb begin
      shadow_nxt = shadow;
      if (wr_ok) begin
         shadow_nxt[wr_idx] = cfg_data;
      end
      chg_nxt = '0;
      for (int i = 0; i < N_PADS; i++) begin
         chg_nxt[i] = (shadow_nxt[i] != active[i]);
      end
   end

   // Only changing pads are parked at SAFE_CFG; every input here is a register.
   always_comb begin
      pad_cfg = '0;
      for (int i = 0; i < N_PADS; i++) begin
         pad_cfg[CFG_W*i +: CFG_W] = ((state == ISOLATE) && chg[i]) ? SAFE_CFG : active[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         guard_cnt  <= '0;
         chg        <= '0;
         rd_data    <= '0;
         addr_err   <= 1'b0;
         commit_err <= 1'b0;
         for (int i = 0; i < N_PADS; i++) begin
            shadow[i] <= DEFAULT_CFG[CFG_W*i +: CFG_W];
            active[i] <= DEFAULT_CFG[CFG_W*i +: CFG_W];
         end
      end else begin
         rd_data <= rd_in_range ? active[rd_idx] : '0;

         // A new error on the same edge as err_clr keeps the flag set.
         if (wr_bad) begin
            addr_err <= 1'b1;
         end else if (err_clr) begin
            addr_err <= 1'b0;
         end
         if (cfg_commit && (state != IDLE)) begin
            commit_err <= 1'b1;
         end else if (err_clr) begin
            commit_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               shadow <= shadow_nxt;
               if (cfg_commit) begin
                  chg <= chg_nxt;
                  if (|chg_nxt) begin
                     state     <= ISOLATE;
                     guard_cnt <= CW'(GUARD_CYC - 1);
                  end else begin
                     state <= APPLY;
                  end
               end
            end
            ISOLATE: begin
               if (guard_cnt == '0) begin
                  state <= APPLY;
               end else begin
                  guard_cnt <= guard_cnt - 1'b1;
               end
            end
            APPLY: begin
               active <= shadow;
               chg    <= '0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_pad_cfg_ctrl.sv
// Self-checking bench for tt_pad_cfg_ctrl against a transaction-level pad model.
// Latency: bench steps one clock per transaction cycle, sampling 1 time unit after the rising edge.
// Backpressure: commit sequences are predicted from the model's change mask, writes only while idle.
module tb_tt_pad_cfg_ctrl;

   localparam int NP = 64;
   localparam int CW = 16;
   localparam int G  = 4;

   // TT-style pad map: pad i defaults to i+1, so SAFE_CFG (0) is always distinguishable.
   function automatic logic [NP*CW-1:0] mk_def();
      logic [NP*CW-1:0] r;
      r = '0;
      for (int i = 0; i < NP; i++) r[CW*i +: CW] = 16'(i + 1);
      return r;
   endfunction

   localparam logic [NP*CW-1:0] DEF  = mk_def();
   // Power/ground pads.
   localparam logic [NP-1:0]    LOCK = (64'h1 << 63) | (64'h1 << 32) | (64'h1 << 31) | 64'h1;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [7:0]        cfg_addr;
   logic [CW-1:0]     cfg_data;
   logic              cfg_commit;
   logic [7:0]        rd_addr;
   logic [CW-1:0]     rd_data;
   logic [NP*CW-1:0]  pad_cfg;
   logic              busy;
   logic              done;
   logic              addr_err;
   logic              commit_err;
   logic              err_clr;

   tt_pad_cfg_ctrl #(
      .N_PADS(NP), .CFG_W(CW), .DEFAULT_CFG(DEF), .LOCK_MASK(LOCK),
      .SAFE_CFG(16'h0000), .GUARD_CYC(G)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .rd_addr(rd_addr), .rd_data(rd_data), .pad_cfg(pad_cfg),
      .busy(busy), .done(done), .addr_err(addr_err), .commit_err(commit_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Reference model: word-level shadow/active tables and sticky flags.
   logic [CW-1:0] m_sh [NP];
   logic [CW-1:0] m_ac [NP];
   logic          m_aerr;
   logic          m_cerr;
   int            vectors = 0;
   int            errors  = 0;

   function automatic logic [NP*CW-1:0] exp_pad(input logic [NP-1:0] iso);
      logic [NP*CW-1:0] r;
      for (int i = 0; i < NP; i++) r[CW*i +: CW] = iso[i] ? 16'h0000 : m_ac[i];
      return r;
   endfunction

   function automatic int first_diff(input logic [NP*CW-1:0] a, input logic [NP*CW-1:0] b);
      for (int i = 0; i < NP; i++) if (a[CW*i +: CW] !== b[CW*i +: CW]) return i;
      return -1;
   endfunction

   function automatic logic [NP-1:0] model_chg();
      logic [NP-1:0] c;
      for (int i = 0; i < NP; i++) c[i] = (m_sh[i] != m_ac[i]);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_reset();
      for (int i = 0; i < NP; i++) begin
         m_sh[i] = DEF[CW*i +: CW];
         m_ac[i] = DEF[CW*i +: CW];
      end
      m_aerr = 1'b0;
      m_cerr = 1'b0;
   endtask

   task automatic m_write(input int a, input logic [CW-1:0] d, input logic clr);
      if (a >= NP || LOCK[a]) m_aerr = 1'b1;
      else begin
         m_sh[a] = d;
         if (clr) m_aerr = 1'b0;
      end
      if (clr) m_cerr = 1'b0;
   endtask

   task automatic test_reset();
      logic [NP*CW-1:0] e;
      int d;
      rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
      cfg_commit = 1'b0; rd_addr = '0; err_clr = 1'b0;
      tick(); tick();
      e = DEF;
      vectors++;
      if (pad_cfg !== e) begin
         errors++; d = first_diff(pad_cfg, e);
         $display("FAIL reset_pad_cfg pad %0d got %h want %h", d, pad_cfg[CW*d +: CW], e[CW*d +: CW]);
      end
      vectors++;
      if ({busy, done, addr_err, commit_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_status got busy/done/aerr/cerr %b want 0000", {busy, done, addr_err, commit_err});
      end
      vectors++;
      if (rd_data !== 16'h0000 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_rd_ready got rd_data %h ready %b want 0000 1", rd_data, cfg_ready);
      end
      rst = 1'b0;
      m_reset();
      rd_addr = 8'd8;
      tick();
      vectors++;
      if (rd_data !== 16'h0009) begin
         errors++;
         $display("FAIL reset_readback8 got %h want 0009", rd_data);
      end
   endtask

   task automatic do_write(input int a, input logic [CW-1:0] d, input logic clr);
      int r;
      r = $urandom_range(0, 70);
      vectors++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_ready got %b want 1", cfg_ready);
      end
      cfg_valid = 1'b1; cfg_addr = 8'(a); cfg_data = d; err_clr = clr; rd_addr = 8'(r);
      tick();
      cfg_valid = 1'b0; err_clr = 1'b0;
      m_write(a, d, clr);
      vectors++;
      if (addr_err !== m_aerr || commit_err !== m_cerr) begin
         errors++;
         $display("FAIL write_flags addr %0d got aerr %b cerr %b want %b %b", a, addr_err, commit_err, m_aerr, m_cerr);
      end
      vectors++;
      if (rd_data !== ((r < NP) ? m_ac[r] : 16'h0000)) begin
         errors++;
         $display("FAIL readback addr %0d got %h want %h", r, rd_data, (r < NP) ? m_ac[r] : 16'h0000);
      end
   endtask

   // Commit from idle, optionally with a write on the same edge, checked cycle by cycle.
   task automatic do_commit(input logic wr, input int a, input logic [CW-1:0] d);
      logic [NP-1:0] c;
      logic [NP*CW-1:0] e;
      int dd;
      int r;
      cfg_commit = 1'b1;
      if (wr) begin cfg_valid = 1'b1; cfg_addr = 8'(a); cfg_data = d; end
      tick();
      cfg_commit = 1'b0; cfg_valid = 1'b0;
      if (wr) m_write(a, d, 1'b0);
      c = model_chg();
      if (c != '0) begin
         for (int k = 1; k <= G; k++) begin
            vectors++;
            if ({busy, cfg_ready, done} !== 3'b100) begin
               errors++;
               $display("FAIL isolate_status cyc %0d got busy/ready/done %b want 100", k, {busy, cfg_ready, done});
            end
            e = exp_pad(c);
            vectors++;
            if (pad_cfg !== e) begin
               errors++; dd = first_diff(pad_cfg, e);
               $display("FAIL isolate_pad cyc %0d pad %0d got %h want %h", k, dd, pad_cfg[CW*dd +: CW], e[CW*dd +: CW]);
            end
            tick();
         end
      end
      vectors++;
      if ({busy, cfg_ready, done} !== 3'b101) begin
         errors++;
         $display("FAIL apply_status got busy/ready/done %b want 101", {busy, cfg_ready, done});
      end
      e = exp_pad('0);
      vectors++;
      if (pad_cfg !== e) begin
         errors++; dd = first_diff(pad_cfg, e);
         $display("FAIL apply_pad pad %0d got %h want %h", dd, pad_cfg[CW*dd +: CW], e[CW*dd +: CW]);
      end
      for (int i = 0; i < NP; i++) m_ac[i] = m_sh[i];
      r = $urandom_range(0, NP - 1);
      rd_addr = 8'(r);
      tick();
      vectors++;
      if ({busy, cfg_ready, done} !== 3'b010) begin
         errors++;
         $display("FAIL post_commit_status got busy/ready/done %b want 010", {busy, cfg_ready, done});
      end
      e = exp_pad('0);
      vectors++;
      if (pad_cfg !== e) begin
         errors++; dd = first_diff(pad_cfg, e);
         $display("FAIL post_commit_pad pad %0d got %h want %h", dd, pad_cfg[CW*dd +: CW], e[CW*dd +: CW]);
      end
      vectors++;
      if (addr_err !== m_aerr || commit_err !== m_cerr) begin
         errors++;
         $display("FAIL commit_flags got aerr %b cerr %b want %b %b", addr_err, commit_err, m_aerr, m_cerr);
      end
      tick();
      vectors++;
      if (rd_data !== m_ac[r]) begin
         errors++;
         $display("FAIL post_commit_readback addr %0d got %h want %h", r, rd_data, m_ac[r]);
      end
   endtask

   task automatic test_write_commit();
      do_write(8, 16'h000B, 1'b0);
      do_commit(1'b0, 0, '0);
      vectors++;
      if (pad_cfg[CW*8 +: CW] !== 16'h000B || pad_cfg[CW*9 +: CW] !== 16'h000A) begin
         errors++;
         $display("FAIL pad8_pad9_final got %h %h want 000b 000a", pad_cfg[CW*8 +: CW], pad_cfg[CW*9 +: CW]);
      end
   endtask

   task automatic test_no_change();
      do_commit(1'b0, 0, '0);
   endtask

   task automatic test_addr_err();
      do_write(64, 16'h1234, 1'b0);
      do_write(63, 16'h5555, 1'b0);
      do_write(5, 16'h0F0F, 1'b1);
      do_write(70, 16'h4444, 1'b1);
      do_commit(1'b0, 0, '0);
      vectors++;
      if (pad_cfg[CW*63 +: CW] !== 16'h0040) begin
         errors++;
         $display("FAIL locked_pad63 got %h want 0040", pad_cfg[CW*63 +: CW]);
      end
   endtask

   task automatic test_busy_collision();
      logic [NP-1:0] c;
      logic [NP*CW-1:0] e;
      int dd;
      do_write(20, 16'hABCD, 1'b0);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      c = model_chg();
      for (int k = 1; k <= G; k++) begin
         e = exp_pad(c);
         vectors++;
         if (pad_cfg !== e || cfg_ready !== 1'b0) begin
            errors++; dd = first_diff(pad_cfg, e);
            $display("FAIL collision_isolate cyc %0d pad %0d got %h ready %b want %h ready 0", k, dd,
                     pad_cfg[CW*((dd < 0) ? 0 : dd) +: CW], cfg_ready, e[CW*((dd < 0) ? 0 : dd) +: CW]);
         end
         if (k == 2) begin
            cfg_commit = 1'b1; cfg_valid = 1'b1; cfg_addr = 8'd21; cfg_data = 16'h7777;
         end
         tick();
         if (k == 2) begin
            cfg_commit = 1'b0; cfg_valid = 1'b0;
            m_cerr = 1'b1;
         end
         vectors++;
         if (commit_err !== m_cerr) begin
            errors++;
            $display("FAIL collision_commit_err cyc %0d got %b want %b", k, commit_err, m_cerr);
         end
      end
      vectors++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL collision_done got %b want 1", done);
      end
      for (int i = 0; i < NP; i++) m_ac[i] = m_sh[i];
      tick();
      e = exp_pad('0);
      vectors++;
      if (pad_cfg !== e || busy !== 1'b0) begin
         errors++; dd = first_diff(pad_cfg, e);
         $display("FAIL collision_final pad %0d busy %b got %h want %h", dd, busy,
                  pad_cfg[CW*((dd < 0) ? 0 : dd) +: CW], e[CW*((dd < 0) ? 0 : dd) +: CW]);
      end
   endtask

   task automatic test_reset_mid();
      int dd;
      do_write(10, 16'h00AA, 1'b0);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      tick();
      vectors++;
      if (pad_cfg[CW*10 +: CW] !== 16'h0000) begin
         errors++;
         $display("FAIL midreset_isolating got %h want 0000", pad_cfg[CW*10 +: CW]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_reset();
      vectors++;
      if (pad_cfg !== DEF) begin
         errors++; dd = first_diff(pad_cfg, DEF);
         $display("FAIL midreset_pad pad %0d got %h want %h", dd, pad_cfg[CW*dd +: CW], DEF[CW*dd +: CW]);
      end
      vectors++;
      if ({busy, cfg_ready, commit_err, addr_err} !== 4'b0100) begin
         errors++;
         $display("FAIL midreset_status got busy/ready/cerr/aerr %b want 0100", {busy, cfg_ready, commit_err, addr_err});
      end
      // Shadow edit must be gone: this commit sees no changes.
      do_commit(1'b0, 0, '0);
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(0, 3);
         for (int w = 0; w < n; w++)
            do_write($urandom_range(0, 69), 16'($urandom), ($urandom_range(0, 7) == 0));
         do_commit(1'($urandom_range(0, 1)), $urandom_range(0, 69), 16'($urandom));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_commit();
      test_no_change();
      test_addr_err();
      test_busy_collision();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
